// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Op encodings match funct3 as decoded by the EX-stage decoder.
// Contents:
//   XLEN, CNT_W  operand width and iteration-counter width
//   op_t         funct3 op encodings (MUL..REMU)
//   state_t      FSM states IDLE/CALC/FIX/DONE
//   a_signed / b_signed  whether an operand is treated as two's complement
package mdu_iter_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic a_signed(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Signals:
//   start_i, op_i, a_i, b_i   request and post-forwarding operands
//   flush_i                   pipeline flush, aborts any op
//   ack_i                     consumer has taken the result
//   ready_o, busy_o, done_o   handshake / stall status
//   result_o                  registered 32-bit result
// Modports: master = EX stage side, slave = the unit.
interface mdu_iter_if;
  import mdu_iter_pkg::*;

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            ack_i;
  logic            ready_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, ack_i,
    input  ready_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, ack_i,
    output ready_o, busy_o, done_o, result_o
  );

endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies by radix-2 shift-add on unsigned magnitudes, divides by
// restoring division, then applies the sign in a single FIX cycle.
// Divide-by-zero and signed overflow bypass the datapath and finish at once.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_iter_if.slave (request, flush, ack, status, result)
module mdu_iter
  import mdu_iter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mdu_iter_if.slave bus
);

  state_t              state_reg, state_next;
  op_t                 op_reg, op_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                neg_reg, neg_next;
  logic [XLEN-1:0]     opnd_reg, opnd_next;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_reg, acc_next;      // product, or quotient in the low word
  logic [XLEN-1:0]     rem_reg, rem_next;      // divider partial remainder
  logic [XLEN-1:0]     result_reg, result_next;

  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? neg32(v) : v;
  endfunction

  op_t             op_in;
  logic            sgn_a, sgn_b, accept, div0, ovf;
  logic [XLEN-1:0] abs_a, abs_b, special_val, quo_fix, rem_fix;
  logic [XLEN:0]   mul_sum, rem_shift, diff;
  logic [2*XLEN-1:0] prod;

  assign op_in = op_t'(bus.op_i);
  assign sgn_a = a_signed(op_in);
  assign sgn_b = b_signed(op_in);
  assign abs_a = abs32(bus.a_i, sgn_a);
  assign abs_b = abs32(bus.b_i, sgn_b);

  assign bus.ready_o  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && bus.ack_i);
  assign bus.busy_o   = (state_reg == S_CALC) || (state_reg == S_FIX);
  assign bus.done_o   = (state_reg == S_DONE);
  assign bus.result_o = result_reg;

  // flush wins over a simultaneous start
  assign accept = bus.start_i && bus.ready_o && !bus.flush_i;

  assign div0 = op_in[2] && (bus.b_i == '0);
  assign ovf  = (op_in == OP_DIV || op_in == OP_REM) &&
                (bus.a_i == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_i == '1);
  // REM/REMU have op bit 1 set: they return the dividend (div0) or zero (ovf)
  assign special_val = div0 ? (op_in[1] ? bus.a_i : '1)
                            : (op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Multiply step: add multiplicand into the high word when the current
  // multiplier bit (acc[0]) is set, then shift the whole 65-bit value right.
  assign mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);

  // Divide step: bring the next dividend bit into the remainder and try the
  // subtraction; a borrow in bit XLEN means the divisor did not fit.
  assign rem_shift = {rem_reg, acc_reg[XLEN-1]};
  assign diff      = rem_shift - {1'b0, opnd_reg};

  assign prod    = neg_reg ? neg64(acc_reg) : acc_reg;
  assign quo_fix = neg_reg ? neg32(acc_reg[XLEN-1:0]) : acc_reg[XLEN-1:0];
  assign rem_fix = neg_reg ? neg32(rem_reg) : rem_reg;

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;
    opnd_next   = opnd_reg;
    acc_next    = acc_reg;
    rem_next    = rem_reg;
    result_next = result_reg;

    case (state_reg)
      S_CALC: begin
        if (op_reg[2]) begin
          if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            acc_next = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], 1'b1};
          end else begin
            rem_next = rem_shift[XLEN-1:0];
            acc_next = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_next = {mul_sum, acc_reg[XLEN-1:1]};
        end
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(XLEN-1)) state_next = S_FIX;
      end
      S_FIX: begin
        case (op_reg)
          OP_MUL:                       result_next = prod[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_next = quo_fix;
          default:                      result_next = rem_fix;
        endcase
        state_next = S_DONE;
      end
      S_DONE: if (bus.ack_i) state_next = S_IDLE;
      default: ;
    endcase

    if (accept) begin
      op_next  = op_in;
      cnt_next = '0;
      rem_next = '0;
      // REM follows the dividend sign; everything else is the XOR of the
      // signs of whichever operands are signed for this op.
      neg_next = (op_in == OP_REM) ? bus.a_i[XLEN-1]
               : ((sgn_a & bus.a_i[XLEN-1]) ^ (sgn_b & bus.b_i[XLEN-1]));
      if (op_in[2]) begin
        acc_next  = {{XLEN{1'b0}}, abs_a};
        opnd_next = abs_b;
      end else begin
        acc_next  = {{XLEN{1'b0}}, abs_b};
        opnd_next = abs_a;
      end
      if (div0 || ovf) begin
        result_next = special_val;
        state_next  = S_DONE;
      end else begin
        state_next = S_CALC;
      end
    end

    if (bus.flush_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      op_reg     <= OP_MUL;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
      opnd_reg   <= opnd_next;
      acc_reg    <= acc_next;
      rem_reg    <= rem_next;
      result_reg <= result_next;
    end
  end

endmodule
